// File: rtl/booth_pkg.sv
// ----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the Booth multiplier sequencer:
//   - state_t      : controller FSM states
//   - ADDR_*       : Avalon word addresses of the register map
//   - CSR_*        : bit positions inside the CTRL/STATUS register
// ----------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_OPA = 2'd0;
    localparam logic [1:0] ADDR_OPB = 2'd1;
    localparam logic [1:0] ADDR_CSR = 2'd2;
    localparam logic [1:0] ADDR_RES = 2'd3;

    localparam int CSR_START  = 0;
    localparam int CSR_DONE   = 1;
    localparam int CSR_IRQ_EN = 2;

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// booth_seq_ctrl_if
// Avalon-MM slave bus plus result/status outputs of the Booth sequencer.
//   address    : word address (OPA, OPB, CTRL/STATUS, RESULT)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : read data, zero read latency
//   out_port   : last completed product (RES_W bits)
//   busy       : multiplication in progress
//   irq        : done AND irq_en
// master drives the bus side; slave is the sequencer.
// ----------------------------------------------------------------------------
interface booth_seq_ctrl_if #(
    parameter int OP_W = 6
);
    localparam int RES_W = 2 * OP_W;

    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [RES_W-1:0] out_port;
    logic             busy;
    logic             irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, out_port, busy, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, out_port, busy, irq
    );

endinterface

// File: rtl/booth_step_dp.sv
// ----------------------------------------------------------------------------
// booth_step_dp
// One combinational radix-2 Booth step: conditional add/subtract of the
// multiplicand followed by an arithmetic right shift of {A,Q,q_m1}.
//   i_a    : accumulator (OP_W+1 bits, signed)
//   i_q    : multiplier / low product bits
//   i_qm1  : bit shifted out of Q on the previous step
//   i_m    : multiplicand, sign-extended to OP_W+1 bits
//   o_a, o_q, o_qm1 : values after the step
// ----------------------------------------------------------------------------
module booth_step_dp #(
    parameter int OP_W = 6
) (
    input  logic signed [OP_W:0]   i_a,
    input  logic        [OP_W-1:0] i_q,
    input  logic                   i_qm1,
    input  logic signed [OP_W:0]   i_m,
    output logic signed [OP_W:0]   o_a,
    output logic        [OP_W-1:0] o_q,
    output logic                   o_qm1
);

    logic signed [OP_W:0] w_sum;

    always_comb begin
        w_sum = i_a;
        case ({i_q[0], i_qm1})
            2'b01:   w_sum = i_a + i_m;
            2'b10:   w_sum = i_a - i_m;
            default: w_sum = i_a;
        endcase
    end

    // Arithmetic shift: the accumulator MSB is replicated, its LSB drops into Q.
    assign o_a   = {w_sum[OP_W], w_sum[OP_W:1]};
    assign o_q   = {w_sum[0], i_q[OP_W-1:1]};
    assign o_qm1 = i_q[0];

endmodule

// File: rtl/booth_seq_ctrl.sv
// ----------------------------------------------------------------------------
// booth_seq_ctrl
// Avalon-MM slave that sequences a radix-2 Booth multiplication, one step
// per clock, and publishes the product on out_port.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : booth_seq_ctrl_if.slave (Avalon slave + out_port/busy/irq)
// Register map: 0 OPA, 1 OPB, 2 CTRL/STATUS, 3 RESULT (read only).
// Latency: start accepted at edge T -> product and done at edge T+OP_W+2.
// ----------------------------------------------------------------------------
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter  int OP_W  = 6,
    localparam int RES_W = 2 * OP_W
) (
    input  logic clk,
    input  logic reset,
    booth_seq_ctrl_if.slave bus
);

    localparam int CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

    // Register file and status
    logic signed [OP_W-1:0]  r_opa;
    logic signed [OP_W-1:0]  r_opb;
    logic                    r_irq_en;
    logic                    r_done;
    logic                    r_busy;
    logic        [RES_W-1:0] r_result;

    // Sequencer state and Booth working registers
    state_t                  r_state;
    logic        [CNT_W-1:0] r_cnt;
    logic signed [OP_W:0]    r_m;
    logic signed [OP_W:0]    r_a;
    logic        [OP_W-1:0]  r_q;
    logic                    r_qm1;

    logic                    w_wr;
    logic                    w_wr_opa;
    logic                    w_wr_opb;
    logic                    w_wr_csr;
    logic                    w_start;
    logic                    w_clr_done;
    logic signed [OP_W:0]    w_a_nxt;
    logic        [OP_W-1:0]  w_q_nxt;
    logic                    w_qm1_nxt;
    logic                    w_unused_wd;

    assign w_wr       = bus.chipselect & ~bus.write_n;
    assign w_wr_opa   = w_wr & (bus.address == ADDR_OPA);
    assign w_wr_opb   = w_wr & (bus.address == ADDR_OPB);
    assign w_wr_csr   = w_wr & (bus.address == ADDR_CSR);
    assign w_start    = w_wr_csr & bus.writedata[CSR_START];
    assign w_clr_done = w_wr_csr & bus.writedata[CSR_DONE];

    // Upper writedata bits carry no meaning in this register map.
    assign w_unused_wd = &{1'b0, bus.writedata};

    booth_step_dp #(
        .OP_W (OP_W)
    ) u_step (
        .i_a   (r_a),
        .i_q   (r_q),
        .i_qm1 (r_qm1),
        .i_m   (r_m),
        .o_a   (w_a_nxt),
        .o_q   (w_q_nxt),
        .o_qm1 (w_qm1_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_m      <= '0;
            r_a      <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
        end else begin
            if (w_wr_opa) r_opa <= bus.writedata[OP_W-1:0];
            if (w_wr_opb) r_opb <= bus.writedata[OP_W-1:0];
            if (w_wr_csr) r_irq_en <= bus.writedata[CSR_IRQ_EN];

            // A clear issued while DONE sets the flag is overridden below.
            if (w_clr_done) r_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                LOAD: begin
                    // Snapshot operands; later register writes do not disturb the run.
                    r_m     <= {r_opb[OP_W-1], r_opb};
                    r_q     <= r_opa;
                    r_a     <= '0;
                    r_qm1   <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= STEP;
                end
                STEP: begin
                    r_a   <= w_a_nxt;
                    r_q   <= w_q_nxt;
                    r_qm1 <= w_qm1_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) r_state <= DONE;
                end
                DONE: begin
                    r_result <= {r_a[OP_W-1:0], r_q};
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_OPA: bus.readdata = 32'(r_opa);
            ADDR_OPB: bus.readdata = 32'(r_opb);
            ADDR_CSR: begin
                bus.readdata[CSR_START]  = r_busy;
                bus.readdata[CSR_DONE]   = r_done;
                bus.readdata[CSR_IRQ_EN] = r_irq_en;
            end
            ADDR_RES: bus.readdata = 32'($signed(r_result));
            default:  bus.readdata = '0;
        endcase
    end

    assign bus.out_port = r_result;
    assign bus.busy     = r_busy;
    assign bus.irq      = r_done & r_irq_en;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_booth_seq_ctrl
// Scoreboard bench for booth_seq_ctrl. Accepted starts push the expected
// product (plain signed multiply) and start edge into a queue; a monitor
// pops on every busy fall and checks out_port, latency and irq.
// ----------------------------------------------------------------------------
module tb_booth_seq_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    booth_seq_ctrl_if #(.OP_W(6)) bus ();

    booth_seq_ctrl #(.OP_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [11:0] prod;
        int          t;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int completions = 0;
    int accepted    = 0;
    int next_free   = 0;

    logic signed [5:0] opa_m = '0;
    logic signed [5:0] opb_m = '0;
    logic              irq_en_m = 1'b0;
    logic [11:0]       last_prod = '0;
    logic              prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sx12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    // Monitor: a busy fall outside reset is a completion.
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
        end else begin
            if (bus.busy) chk("out_port_hold", 32'(bus.out_port), 32'(last_prod));
            if (prev_busy && !bus.busy) begin
                completions++;
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_completion: got out_port 0x%0h, expected no completion", bus.out_port);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_port", 32'(bus.out_port), 32'(mon_e.prod));
                    chk("latency", 32'(cyc), 32'(mon_e.t + 8));
                    chk("irq_at_done", 32'(bus.irq), 32'(irq_en_m));
                    last_prod = mon_e.prod;
                end
            end
            prev_busy = bus.busy;
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        int edge_n;
        int p;
        edge_n = cyc + 1;
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(posedge clk);
        case (a)
            2'd0: opa_m = d[5:0];
            2'd1: opb_m = d[5:0];
            2'd2: begin
                irq_en_m = d[2];
                if (d[0] && edge_n >= next_free) begin
                    p = int'(opa_m) * int'(opb_m);
                    q.push_back('{prod: p[11:0], t: edge_n});
                    next_free = edge_n + 9;
                    accepted++;
                end
            end
            default: ;
        endcase
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(negedge clk);
        d = bus.readdata;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL completion_timeout: got %0d pending, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        q.delete();
        opa_m     = '0;
        opb_m     = '0;
        irq_en_m  = 1'b0;
        next_free = 0;
        last_prod = '0;
        #1;
        reset = 1'b0;
    endtask

    // Directed op: start together with clear-done, so done reads 0 right after.
    task automatic run_op(input string name, input logic [5:0] a, input logic [5:0] b,
                          input logic [11:0] exp);
        logic [31:0] d;
        wr(2'd0, {26'd0, a});
        wr(2'd1, {26'd0, b});
        wr(2'd2, {29'd0, irq_en_m, 2'b11});
        rd(2'd2, d);
        chk({name, "_csr_running"}, d, {29'd0, irq_en_m, 2'b01});
        wait_idle();
        rd(2'd3, d);
        chk({name, "_result"}, d, sx12(exp));
        rd(2'd2, d);
        chk({name, "_csr_done"}, d, {29'd0, irq_en_m, 2'b10});
    endtask

    initial begin
        logic [31:0] d;
        int n;
        int c0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        reset          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), d);
            chk("reset_reg", d, 32'd0);
        end
        @(negedge clk);
        chk("reset_out_port", 32'(bus.out_port), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_irq", 32'(bus.irq), 32'd0);
        @(posedge clk);
        #1;

        // Basic 3 x 5 with busy length
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd5);
        wr(2'd2, 32'd1);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.busy) n++;
            @(posedge clk);
            #1;
        end
        chk("busy_cycles", 32'(n), 32'd8);
        wait_idle();
        rd(2'd3, d);
        chk("basic_result", d, 32'h0000000F);
        rd(2'd2, d);
        chk("basic_done", d, 32'h2);

        // Mixed sign and extremes
        run_op("neg3x5",    6'h3D, 6'h05, 12'hFF1);
        run_op("m32xm32",   6'h20, 6'h20, 12'h400);
        run_op("31xm32",    6'h1F, 6'h20, 12'hC20);
        run_op("0xm17",     6'h00, 6'h2F, 12'h000);

        // Start while busy and operand rewrite during the run
        wr(2'd0, 32'h39);
        wr(2'd1, 32'd9);
        c0 = completions;
        wr(2'd2, 32'd1);
        idle(2);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'd7);
        wait_idle();
        idle(12);
        chk("single_completion", 32'(completions - c0), 32'd1);
        rd(2'd0, d);
        chk("opa_rewritten", d, 32'd7);
        rd(2'd3, d);
        chk("busy_start_result", d, 32'hFFFFFFC1);

        // Interrupt handling
        wr(2'd2, 32'h6);
        @(negedge clk);
        chk("irq_after_clear", 32'(bus.irq), 32'd0);
        @(posedge clk);
        #1;
        run_op("irq_op", 6'd3, 6'd5, 12'h00F);
        @(negedge clk);
        chk("irq_high", 32'(bus.irq), 32'd1);
        @(posedge clk);
        #1;
        wr(2'd2, 32'h6);
        rd(2'd2, d);
        chk("clear_done_csr", d, 32'h4);
        @(negedge clk);
        chk("clear_done_irq", 32'(bus.irq), 32'd0);
        @(posedge clk);
        #1;
        wr(2'd2, 32'h5);
        idle(7);
        wr(2'd2, 32'h6);
        rd(2'd2, d);
        chk("set_beats_clear", d, 32'h6);
        @(negedge clk);
        chk("set_beats_clear_irq", 32'(bus.irq), 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-operation
        wr(2'd0, 32'h2A);
        wr(2'd1, 32'h13);
        wr(2'd2, 32'd1);
        idle(3);
        do_reset();
        @(negedge clk);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_out_port", 32'(bus.out_port), 32'd0);
        chk("rst_mid_irq", 32'(bus.irq), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), d);
            chk("rst_mid_reg", d, 32'd0);
        end
        idle(12);
        run_op("post_reset", 6'd3, 6'd5, 12'h00F);

        // Random regression with traffic during busy
        c0 = accepted;
        for (int it = 0; it < 20000 && (accepted - c0) < 500; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: wr(2'd2, $urandom | 32'd1);
                4, 5:       wr(2'd0, $urandom);
                6, 7:       wr(2'd1, $urandom);
                8:          wr(2'd3, $urandom);
                default:    idle($urandom_range(1, 3));
            endcase
        end
        wait_idle();
        chk("random_count", 32'(accepted - c0), 32'd500);
        rd(2'd3, d);
        chk("random_last_result", d, sx12(last_prod));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
